// File: rtl/bank_read_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bank_read_streamer_pkg
// Brief    : Shared types and constants for the banked read streamer.
// Revision : 1.0 - initial release
// ============================================================================
package bank_read_streamer_pkg;

    localparam int C_DEF_DATA_WIDTH  = 16;
    localparam int C_DEF_ADDR_WIDTH  = 13;
    localparam int C_DEF_NUM_BANKS   = 8;
    localparam int C_DEF_COUNT_WIDTH = 16;

    localparam int C_BUF_DEPTH = 2;
    localparam int C_BUF_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Rows committed after this cycle, not counting a request made this cycle.
    function automatic logic [2:0] f_occupancy(
        input logic [C_BUF_CNT_W-1:0] count,
        input logic                   inflight,
        input logic                   pop
    );
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage : bank_read_streamer_pkg
`default_nettype wire

// File: rtl/bank_read_streamer_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_skid_fifo
// Brief    : 2-entry FIFO with registered head data/last; no fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module stream_skid_fifo
    import bank_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_push_data,
    input  logic                   i_push_last,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_head_data,
    output logic                   o_head_last,
    output logic [C_BUF_CNT_W-1:0] o_count
);

    logic [DATA_WIDTH-1:0]  r_head_data;
    logic                   r_head_last;
    logic [DATA_WIDTH-1:0]  r_tail_data;
    logic                   r_tail_last;
    logic [C_BUF_CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    localparam logic [C_BUF_CNT_W-1:0] C_FULL = C_BUF_CNT_W'(C_BUF_DEPTH);

    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count != C_FULL) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
            r_count     <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_head_data <= i_push_data;
                        r_head_last <= i_push_last;
                    end else begin
                        r_tail_data <= i_push_data;
                        r_tail_last <= i_push_last;
                    end
                    r_count <= r_count + C_BUF_CNT_W'(1);
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_count     <= r_count - C_BUF_CNT_W'(1);
                end
                2'b11: begin
                    // Count is unchanged; the new row lands behind whatever remains.
                    if (r_count == C_BUF_CNT_W'(1)) begin
                        r_head_data <= i_push_data;
                        r_head_last <= i_push_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= i_push_data;
                        r_tail_last <= i_push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid     = (r_count != '0);
    assign o_head_data = r_head_data;
    assign o_head_last = r_head_last;
    assign o_count     = r_count;

endmodule : stream_skid_fifo
`default_nettype wire

// File: rtl/bank_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bank_read_streamer
// Brief    : Strided lockstep bank reader delivering rows on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module bank_read_streamer
    import bank_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH  = C_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = C_DEF_ADDR_WIDTH,
    parameter int NUM_BANKS   = C_DEF_NUM_BANKS,
    parameter int COUNT_WIDTH = C_DEF_COUNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [ADDR_WIDTH-1:0]           i_cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]           i_cfg_stride,
    input  logic [COUNT_WIDTH-1:0]          i_cfg_num_words,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [NUM_BANKS-1:0]            o_bs_read_req,
    output logic [NUM_BANKS*ADDR_WIDTH-1:0] o_bs_read_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bs_read_data,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_out_data,
    output logic                            o_out_last
);

    localparam int C_ROW_W = NUM_BANKS * DATA_WIDTH;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic [ADDR_WIDTH-1:0]  r_next_addr;
    logic [ADDR_WIDTH-1:0]  r_last_addr;
    logic [ADDR_WIDTH-1:0]  r_stride;
    logic [COUNT_WIDTH-1:0] r_num;
    logic [COUNT_WIDTH-1:0] r_issued;
    logic                   r_inflight;
    logic                   r_inflight_last;

    logic                   w_pop;
    logic [C_BUF_CNT_W-1:0] w_buf_count;
    logic [2:0]             w_occ;
    logic                   w_req;
    logic                   w_final_issue;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_pop = o_out_valid & i_out_ready;
    assign w_occ = f_occupancy(w_buf_count, r_inflight, w_pop);

    // Capping occupancy at two guarantees a returning read always finds space.
    assign w_req         = (r_state == ST_STREAM) && (w_occ < 3'd2) && (r_issued < r_num);
    assign w_final_issue = w_req && (r_issued == (r_num - COUNT_WIDTH'(1)));
    assign w_addr        = w_req ? r_next_addr : r_last_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_next_addr     <= '0;
            r_last_addr     <= '0;
            r_stride        <= '0;
            r_num           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_req;
            r_inflight_last <= w_final_issue;

            if (w_req) begin
                r_last_addr <= r_next_addr;
                r_next_addr <= r_next_addr + r_stride;
                r_issued    <= r_issued + COUNT_WIDTH'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_stride    <= i_cfg_stride;
                        r_num       <= i_cfg_num_words;
                        r_next_addr <= i_cfg_base_addr;
                        r_issued    <= '0;
                        if (i_cfg_num_words == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_STREAM;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_final_issue) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave as the final row is popped so done lands right after it.
                    if (w_occ == 3'd0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    stream_skid_fifo #(
        .DATA_WIDTH (C_ROW_W)
    ) u_skid_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (i_bs_read_data),
        .i_push_last (r_inflight_last),
        .i_pop       (i_out_ready),
        .o_valid     (o_out_valid),
        .o_head_data (o_out_data),
        .o_head_last (o_out_last),
        .o_count     (w_buf_count)
    );

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_bs_read_req  = {NUM_BANKS{w_req}};
    assign o_bs_read_addr = {NUM_BANKS{w_addr}};

endmodule : bank_read_streamer
`default_nettype wire

// File: tb/tb_bank_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_read_streamer
// Brief    : Self-checking bench with a scratchpad model and row scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_read_streamer;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int NB = 8;
    localparam int CW = 16;
    localparam int RW = NB * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_stride = '0;
    logic [CW-1:0] cfg_num = '0;
    logic          busy;
    logic          done;
    logic [NB-1:0] req;
    logic [NB*AW-1:0] addr;
    logic [RW-1:0] rdata = '0;
    logic          valid;
    logic          ready = 1'b0;
    logic [RW-1:0] odata;
    logic          last;
    logic [15:0]   salt = 16'h1234;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bank_read_streamer #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_BANKS (NB), .COUNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_cfg_base_addr (cfg_base),
        .i_cfg_stride    (cfg_stride),
        .i_cfg_num_words (cfg_num),
        .o_busy          (busy),
        .o_done          (done),
        .o_bs_read_req   (req),
        .o_bs_read_addr  (addr),
        .i_bs_read_data  (rdata),
        .o_out_valid     (valid),
        .i_out_ready     (ready),
        .o_out_data      (odata),
        .o_out_last      (last)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int b, input logic [15:0] s);
        logic [31:0] t;
        t = (32'(a) * 32'h9E37) ^ (32'(b) * 32'h1F1F) ^ 32'(s);
        return t[DW-1:0];
    endfunction

    function automatic logic [RW-1:0] exp_row(input logic [AW-1:0] a, input logic [15:0] s);
        logic [RW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = pat(a, b, s);
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int k);
        longint v;
        v = longint'(b) + longint'(s) * longint'(k);
        return v[AW-1:0];
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b0;
        endcase
    endfunction

    // Scratchpad: one-cycle read latency, per-bank address decode.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (req[b]) rdata[b*DW +: DW] <= pat(addr[b*AW +: AW], b, salt);
    end

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  RW'(busy),  '0);
        chk({tag, "_done"},  RW'(done),  '0);
        chk({tag, "_req"},   RW'(req),   '0);
        chk({tag, "_addr"},  RW'(addr),  '0);
        chk({tag, "_valid"}, RW'(valid), '0);
        chk({tag, "_last"},  RW'(last),  '0);
        chk({tag, "_data"},  odata,      '0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int num,
                           input int mode, input bit timed, input int restart_at);
        int nreq = 0, npop = 0, last_pop_cyc = -1, cyc = 0;
        bit fin = 0, pop;
        logic prev_stall, prev_last;
        logic [RW-1:0] prev_data;
        @(negedge clk);
        cfg_base = base; cfg_stride = stride; cfg_num = CW'(num); start = 1'b1;
        ready = rdy(mode, 0);
        #1;
        chk("idle_busy", RW'(busy), '0);
        chk("idle_req", RW'(req), '0);
        prev_stall = valid & ~ready; prev_data = odata; prev_last = last;
        while (!fin) begin
            cyc++;
            @(negedge clk);
            start = (cyc == restart_at);
            cfg_base = AW'($urandom); cfg_stride = AW'($urandom); cfg_num = CW'($urandom_range(1, 9));
            ready = rdy(mode, cyc);
            #1;
            if (prev_stall) begin
                chk("stall_valid", RW'(valid), RW'(1));
                chk("stall_data", odata, prev_data);
                chk("stall_last", RW'(last), RW'(prev_last));
            end
            chk("req_lockstep", RW'(req), RW'({NB{req[0]}}));
            if (req[0]) begin
                chk("req_within_num", RW'(nreq < num), RW'(1));
                for (int b = 0; b < NB; b++)
                    chk("req_addr", RW'(addr[b*AW +: AW]), RW'(exp_addr(base, stride, nreq)));
                nreq++;
            end
            pop = valid & ready;
            if (pop) begin
                chk("row_data", odata, exp_row(exp_addr(base, stride, npop), salt));
                chk("row_last", RW'(last), RW'(npop == num - 1));
                npop++;
                last_pop_cyc = cyc;
            end
            chk("outstanding", RW'((nreq - npop) <= 2), RW'(1));
            if (timed) begin
                chk("t_req", RW'(req[0]), RW'(cyc >= 1 && cyc <= num));
                chk("t_valid", RW'(valid), RW'(cyc >= 3 && cyc <= num + 2));
                chk("t_done", RW'(done), RW'(num == 0 ? cyc == 1 : cyc == num + 3));
                chk("t_busy", RW'(busy), RW'(num > 0 && cyc <= num + 2));
            end
            if (done) begin
                chk("done_rows", RW'(npop), RW'(num));
                chk("done_cycle", RW'(cyc), RW'(num == 0 ? 1 : last_pop_cyc + 1));
                chk("done_busy_low", RW'(busy), '0);
                fin = 1;
            end else if (cyc > 60 + 4 * num) begin
                chk("timeout_no_done", RW'(0), RW'(1));
                fin = 1;
            end
            prev_stall = valid & ~ready; prev_data = odata; prev_last = last;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0; ready = 1'b1;
            #1;
            chk("post_done", RW'(done), '0);
            chk("post_valid", RW'(valid), '0);
            chk("post_req", RW'(req), '0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(13'h0010, 13'd1, 4, 0, 1'b1, -1);
        salt = 16'($urandom);
        run_cmd(13'h1FFE, 13'd3, 3, 0, 1'b1, -1);
        salt = 16'($urandom);
        run_cmd(AW'($urandom), AW'($urandom), 8, 1, 1'b0, -1);
        run_cmd(AW'($urandom), AW'($urandom), 0, 0, 1'b1, -1);
        salt = 16'($urandom);
        run_cmd(AW'($urandom), AW'($urandom), 5, 2, 1'b0, 2);

        // Abort a command with a full buffer pipeline, then prove no stale rows leak out.
        @(negedge clk);
        cfg_base = 13'h0100; cfg_stride = 13'd2; cfg_num = 16'd8; start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_reset_valid", RW'(valid), RW'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        salt = 16'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(13'h0100, 13'd2, 2, 0, 1'b1, -1);

        for (int t = 0; t < 6; t++) begin
            int mode;
            mode = $urandom_range(0, 2);
            salt = 16'($urandom);
            run_cmd(AW'($urandom), AW'($urandom), $urandom_range(1, 20), mode, mode == 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bank_read_streamer
`default_nettype wire
